// File: rtl/rv_div_pkg.sv
// ============================================================================
// Module : rv_div_pkg
// Brief  : Shared types and helpers for the RV32M multicycle divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Bit 0 of the funct3-derived opcode marks the unsigned variants.
    function automatic logic div_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_restore_step.sv
// ============================================================================
// Module : div_restore_step
// Brief  : One combinational restoring-division iteration.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    assign w_shifted = {rem_in, dvd_bit};
    assign w_trial   = w_shifted - {1'b0, divisor};

    // A set top bit of the shifted remainder already exceeds any divisor;
    // otherwise a borrow into bit WIDTH means the trial went negative.
    assign q_bit   = w_shifted[WIDTH] | ~w_trial[WIDTH];
    assign rem_out = q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/rv_div_unit.sv
// ============================================================================
// Module : rv_div_unit
// Brief  : Multicycle DIV/DIVU/REM/REMU unit, one restoring step per cycle.
//          Optional early exit for trivial operands: RV_DIV_FAST_PATH_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv_div_unit
    import rv_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int               CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state, state_next;

    logic             r_is_rem;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_abs_a;
    logic [WIDTH-1:0] r_abs_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic             r_ovf;
    logic             r_fast;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_short;
    logic [WIDTH-1:0] w_step_r;
    logic             w_step_q;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_result;

    assign in_ready = (state == IDLE) && !flush;
    assign busy     = (state != IDLE);
    assign w_accept = in_valid && in_ready;

    assign w_signed = div_is_signed(div_op_e'(in_op));
    assign w_a_neg  = w_signed & in_a[WIDTH-1];
    assign w_b_neg  = w_signed & in_b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -in_a : in_a;
    assign w_abs_b  = w_b_neg ? -in_b : in_b;
    assign w_b_zero = (in_b == '0);
    assign w_ovf    = w_signed && (in_a == MIN_VAL) && (in_b == '1);

`ifdef RV_DIV_FAST_PATH_EN
    assign w_short = w_b_zero | w_ovf | (w_abs_a < w_abs_b);
`else
    assign w_short = 1'b0;
`endif

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (r_r),
        .dvd_bit (r_abs_a[r_cnt]),
        .divisor (r_abs_b),
        .rem_out (w_step_r),
        .q_bit   (w_step_q)
    );

    // Special cases take priority over the magnitude result.
    always_comb begin
        w_quot = r_neg_q ? -r_q : r_q;
        w_rem  = r_neg_r ? -r_r : r_r;
        if (r_div_zero) begin
            w_result = r_is_rem ? r_a : '1;
        end else if (r_ovf) begin
            w_result = r_is_rem ? '0 : MIN_VAL;
        end else begin
            w_result = r_is_rem ? w_rem : w_quot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (w_accept) state_next = CALC;
            CALC: if (r_fast || (r_cnt == '0)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            r_is_rem   <= 1'b0;
            r_tag      <= '0;
            r_a        <= '0;
            r_abs_a    <= '0;
            r_abs_b    <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_fast     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_rem   <= in_op[1];
                        r_tag      <= in_tag;
                        r_a        <= in_a;
                        r_abs_a    <= w_abs_a;
                        r_abs_b    <= w_abs_b;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= w_b_zero;
                        r_ovf      <= w_ovf;
                        r_fast     <= w_short;
                        r_q        <= '0;
                        // Early exit with |a| < |b| leaves the dividend as remainder.
                        r_r        <= w_short ? w_abs_a : '0;
                        r_cnt      <= CNT_W'(WIDTH - 1);
                    end
                end
                CALC: begin
                    if (!r_fast) begin
                        r_r        <= w_step_r;
                        r_q[r_cnt] <= w_step_q;
                        r_cnt      <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        out_result <= w_result;
                        out_tag    <= r_tag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_div_unit.sv
// ============================================================================
// Module : tb_rv_div_unit
// Brief  : Scoreboard bench for rv_div_unit (WIDTH=32).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rv_div_unit;
    import rv_div_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
`ifdef RV_DIV_FAST_PATH_EN
    localparam int OVF_LAT = 2;
`else
    localparam int OVF_LAT = 33;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rv_div_unit #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_res, input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL issue_wait in_ready=%b required=1", in_ready);
            return;
        end
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        if (push) sb.push_back('{res: exp_res, tag: tag});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int exp_lat);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_err++;
            $display("FAIL %s timeout out_valid=%b required=1", name, out_valid);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected result=%h required=none", name, out_result);
        end else begin
            e = sb.pop_front();
            if (out_result !== e.res || out_tag !== e.tag) begin
                n_err++;
                $display("FAIL %s result=%h tag=%h required result=%h tag=%h",
                         name, out_result, out_tag, e.res, e.tag);
            end
        end
        if (exp_lat >= 0) begin
            n_cmp++;
            if (n !== exp_lat) begin
                n_err++;
                $display("FAIL %s latency=%0d required=%0d", name, n, exp_lat);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready, out_result, out_tag} !== {1'b0, 1'b0, 1'b1, 32'd0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_values valid=%b busy=%b in_ready=%b result=%h tag=%h required 0 0 1 0 0",
                     out_valid, busy, in_ready, out_result, out_tag);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        issue(2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
        collect("divu_100_7", 33);
        issue(2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 1'b1);
        collect("remu_100_7", 33);
    endtask

    task automatic test_signed();
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 1'b1);
        collect("div_m7_2", -1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 1'b1);
        collect("rem_m7_2", -1);
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, 1'b1);
        collect("div_7_m2", -1);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 1'b1);
        collect("rem_7_m2", -1);
    endtask

    task automatic test_div_zero();
        issue(2'b00, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF, 1'b1);
        collect("div_5_0", -1);
        issue(2'b00, 32'hFFFF_FFFB, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b1);
        collect("div_m5_0", -1);
        issue(2'b01, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b1);
        collect("divu_5_0", -1);
        issue(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd8, 32'hFFFF_FFFB, 1'b1);
        collect("rem_m5_0", -1);
        issue(2'b11, 32'h8000_0000, 32'd0, 5'd9, 32'h8000_0000, 1'b1);
        collect("remu_min_0", -1);
    endtask

    task automatic test_overflow();
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1);
        collect("div_ovf", OVF_LAT);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1'b1);
        collect("rem_ovf", OVF_LAT);
    endtask

    task automatic test_backpressure();
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        int          n = 0;
        exp_t        e;
        issue(2'b01, 32'd1000, 32'd10, 5'h1A, 32'd100, 1'b1);
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL bp_result valid=%b result=%h tag=%h required 1 %h %h",
                     out_valid, out_result, out_tag, e.res, e.tag);
        end
        held_res = out_result;
        held_tag = out_tag;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== held_res || out_tag !== held_tag) begin
                n_err++;
                $display("FAIL bp_hold cycle=%0d valid=%b in_ready=%b result=%h tag=%h required 1 0 %h %h",
                         i, out_valid, in_ready, out_result, out_tag, held_res, held_tag);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        issue(2'b01, 32'hFFFF_FFFF, 32'd3, 5'd12, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle busy=%b valid=%b required 0 0", busy, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) begin
                n_cmp++; n_err++;
                $display("FAIL flush_no_output valid=%b required=0", out_valid);
                break;
            end
        end
        in_valid = 1'b1; in_op = 2'b01; in_a = 32'd9; in_b = 32'd3; in_tag = 5'd13;
        flush = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_in_ready in_ready=%b required=0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wins busy=%b required=0", busy);
        end
        issue(2'b01, 32'hFFFF_FFFF, 32'h10, 5'd14, 32'h0FFF_FFFF, 1'b1);
        collect("divu_after_flush", 33);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case (i % 4)
                0: b = 32'($urandom_range(1, 255));
                1: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                2: b = $urandom;
                default: b = 32'd0;
            endcase
            issue(op, a, b, 5'(i + 16), ref_div(op, a, b), 1'b1);
            collect("b2b_model", -1);
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b00, 32'd12345, 32'd7, 5'd21, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready, out_result, out_tag} !== {1'b0, 1'b0, 1'b1, 32'd0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_mid valid=%b busy=%b in_ready=%b result=%h tag=%h required 0 0 1 0 0",
                     out_valid, busy, in_ready, out_result, out_tag);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
